alu_mc: RTL
===========

# alu_mc

Multi-cycle ALU execute unit: the consumer of the 3-bit `alucontrol` code produced by the ALU decoder. It accepts one operation per valid/ready handshake and returns the result, zero flag and signed-overflow flag through an output valid/ready handshake. Logic and arithmetic ops complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter, so the datapath no longer needs a barrel shifter. It sits in the execute stage between the operand muxes and the result/writeback register.

## Interface
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width (2^SHW >= WIDTH)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- alucontrol  in  3  operation code (encoding below)
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt / immediate); the shift source
- shamt  in  SHW  shift amount
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- overflow  out  1  signed overflow; meaningful for add/sub only, 0 otherwise

## Operation
- Encoding: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed; result = {0…, a<b}), 011 sll b, 100 srl b, 101 sra b.
- FSM states IDLE, SHIFT and DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid with a non-shift op: compute the result, register result/zero/overflow, then go to DONE.
  - On in_valid with a shift op and shamt=0: register b, then go to DONE.
  - On in_valid with a shift op and shamt≠0: load the shift register with b and the counter with shamt, latch the direction, then go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: shift by 1 (sll fills 0 at the LSB, srl fills 0 at the MSB, sra replicates the MSB) and decrement the counter.
  - When the counter goes from 1 to 0: register the result, set zero, then go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs hold stable until out_ready=1, then return to IDLE.
  - A new request is accepted no earlier than the cycle after the output handshake; there is no overlap.
- Overflow:
  - add: a and b have the same sign and the result sign differs.
  - sub: a and b have different signs and the result sign differs from a.
  - All other ops: 0.
- Arithmetic is modulo 2^WIDTH. Operands are sampled only at the input handshake, so later changes on a/b/shamt/alucontrol are ignored.
- out_ready while out_valid=0 is ignored. in_valid in SHIFT or DONE is ignored, and the request is not captured.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, zero=0, overflow=0, FSM=IDLE.
- Asserting rst mid-operation aborts the operation immediately (asynchronously) with the reset values above. The pending result is lost.
- Non-shift op, or shift with shamt=0, accepted at edge k: out_valid=1 after edge k+1 (1-cycle latency).
- Shift with shamt=n>0 accepted at edge k: out_valid=1 after edge k+n+1.
- Throughput, zero-wait consumer: one non-shift op every 2 cycles.
- in_ready is a pure function of state (no combinational path from in_valid). out_valid is registered.

## Configuration
- ALU_MC_SHIFT_EN defined:
  - The SHIFT state, shift register and counter are compiled in.
  - Codes 011/100/101 behave as above.
- ALU_MC_SHIFT_EN undefined:
  - No SHIFT state, shifter or counter.
  - Codes 011/100/101 complete in 1 cycle with result=0, zero=1, overflow=0.
  - shamt is unused.

## Test plan
- Reset, then add a=0x7FFFFFFF, b=1 → next cycle: out_valid=1, result=0x80000000, overflow=1, zero=0.
- sub a=5, b=5 with out_ready held 0 for 3 cycles → result=0, zero=1; outputs stable and in_ready=0 throughout; IDLE one cycle after out_ready=1.
- slt a=0xFFFFFFFF, b=1 → result=1. Then or a=0xF0, b=0x0F → result=0xFF, overflow=0.
- With macro, sra b=0x80000000, shamt=4 → out_valid exactly 5 cycles after accept, result=0xF8000000. Also sll b=1, shamt=0 → result=1 after 1 cycle.
- sll b=1, shamt=31, with rst pulsed at cycle 10 → all outputs at reset values, in_ready=1. A following and a=0xC, b=0xA → result=0x8.
- Without macro, srl b=0x100, shamt=8 → 1-cycle latency, result=0, zero=1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU execute unit with valid/ready handshakes on both sides.
// Define ALU_MC_SHIFT_EN to build the iterative 1-bit-per-cycle shifter (SHIFT state).
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DONE  = 2'd2;
`ifdef ALU_MC_SHIFT_EN
    localparam logic [1:0] SHIFT = 2'd1;
`endif

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       state, state_next;
    logic [WIDTH-1:0] result_next;
    logic             zero_next, overflow_next;
    logic             in_ready_next, out_valid_next;
    logic [WIDTH-1:0] sum, diff;

`ifdef ALU_MC_SHIFT_EN
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [SHW-1:0]   cnt, cnt_next;
    logic [2:0]       dir, dir_next;
`else
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef ALU_MC_SHIFT_EN
            shreg     <= '0;
            cnt       <= '0;
            dir       <= '0;
`endif
        end else begin
            state     <= state_next;
            result    <= result_next;
            zero      <= zero_next;
            overflow  <= overflow_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
`ifdef ALU_MC_SHIFT_EN
            shreg     <= shreg_next;
            cnt       <= cnt_next;
            dir       <= dir_next;
`endif
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_next     = state;
        result_next    = result;
        zero_next      = zero;
        overflow_next  = overflow;
        in_ready_next  = in_ready;
        out_valid_next = out_valid;
        sum            = a + b;
        diff           = a - b;
`ifdef ALU_MC_SHIFT_EN
        shreg_next     = shreg;
        cnt_next       = cnt;
        dir_next       = dir;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next     = DONE;
                    in_ready_next  = 1'b0;
                    out_valid_next = 1'b1;
                    overflow_next  = 1'b0;
                    case (alucontrol)
                        OP_AND: result_next = a & b;
                        OP_OR:  result_next = a | b;
                        OP_ADD: begin
                            result_next   = sum;
                            overflow_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            result_next   = diff;
                            overflow_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SLT: result_next = WIDTH'($signed(a) < $signed(b));
                        default: begin
`ifdef ALU_MC_SHIFT_EN
                            result_next = b;
                            if (shamt != '0) begin
                                shreg_next     = b;
                                cnt_next       = shamt;
                                dir_next       = alucontrol;
                                state_next     = SHIFT;
                                out_valid_next = 1'b0;
                            end
`else
                            result_next = '0;
`endif
                        end
                    endcase
                    zero_next = (result_next == '0);
                end
            end
`ifdef ALU_MC_SHIFT_EN
            // One bit per cycle; the result is committed once the count is exhausted
            SHIFT: begin
                if (cnt == '0) begin
                    result_next    = shreg;
                    zero_next      = (shreg == '0);
                    state_next     = DONE;
                    out_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt - SHW'(1);
                    case (dir)
                        OP_SLL:  shreg_next = {shreg[WIDTH-2:0], 1'b0};
                        OP_SRL:  shreg_next = {1'b0, shreg[WIDTH-1:1]};
                        default: shreg_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
                    endcase
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    in_ready_next  = 1'b1;
                    out_valid_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                in_ready_next  = 1'b1;
                out_valid_next = 1'b0;
            end
        endcase
    end

endmodule
